// File: rtl/spike_maxpool2d_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module  : snn_pool_pkg
// Brief   : FSM encodings, legal kernel/stride bounds and output-size helper
//           shared by the streaming spike max-pool.
// Revision: 1.0 - initial release
// ============================================================================
package snn_pool_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } pool_state_t;

    localparam logic [1:0] c_kernel_min = 2'd2;
    localparam logic [1:0] c_kernel_max = 2'd3;
    localparam logic [1:0] c_stride_min = 2'd1;
    localparam logic [1:0] c_stride_max = 2'd2;

    // Ho = floor((H + 2p - k) / s) + 1; s is restricted to 1 or 2.
    function automatic int calc_out_size(input int h, input int k, input int s, input int p);
        int span;
        span = h + 2 * p - k;
        return ((s == 2) ? (span >>> 1) : span) + 1;
    endfunction

endpackage : snn_pool_pkg
`default_nettype wire

// File: rtl/spike_maxpool2d_stream_if.sv
`default_nettype none
// ============================================================================
// Module  : spike_maxpool2d_stream_if
// Brief   : Row-stream handshake bundle (input rows in, pooled rows out).
// Revision: 1.0 - initial release
// ============================================================================
interface spike_maxpool2d_stream_if #(
    parameter int IMG_WIDTH  = 32,
    parameter int TIME_STEPS = 4
);
    logic                            i_valid;
    logic [IMG_WIDTH*TIME_STEPS-1:0] i_row;
    logic                            i_ready;
    logic                            o_valid;
    logic [IMG_WIDTH*TIME_STEPS-1:0] o_row;
    logic                            o_ready;

    modport master (
        output i_valid, i_row, o_ready,
        input  i_ready, o_valid, o_row
    );

    modport slave (
        input  i_valid, i_row, o_ready,
        output i_ready, o_valid, o_row
    );
endinterface : spike_maxpool2d_stream_if
`default_nettype wire

// File: rtl/spike_maxpool2d_stream_row_or.sv
`default_nettype none
// ============================================================================
// Module  : spike_pool_row_or
// Brief   : Horizontal k-tap / stride-s OR over one row with zero padding,
//           compacting pooled pixels to the low end of the bus.
// Revision: 1.0 - initial release
// ============================================================================
module spike_pool_row_or #(
    parameter int IMG_WIDTH  = 32,
    parameter int TIME_STEPS = 4,
    parameter int CNT_W      = 16
) (
    input  wire  [IMG_WIDTH*TIME_STEPS-1:0] i_win_row,
    input  wire  [CNT_W-1:0]                i_width,
    input  wire  [CNT_W-1:0]                i_out_width,
    input  wire  [1:0]                      i_kernel,
    input  wire  [1:0]                      i_stride,
    input  wire                             i_pad,
    output logic [IMG_WIDTH*TIME_STEPS-1:0] o_pooled_row
);

    for (genvar j = 0; j < IMG_WIDTH; j++) begin : g_pix
        logic [TIME_STEPS-1:0] w_acc;

        // Columns left of 0 or at/after the image width act as zero padding.
        always_comb begin
            int col;
            col   = 0;
            w_acc = '0;
            for (int c = 0; c < 3; c++) begin
                col = j * int'(i_stride) - int'(i_pad) + c;
                if (c < int'(i_kernel) && col >= 0 && col < int'(i_width) && col < IMG_WIDTH)
                    w_acc = w_acc | i_win_row[col*TIME_STEPS +: TIME_STEPS];
            end
        end

        assign o_pooled_row[j*TIME_STEPS +: TIME_STEPS] = (j < int'(i_out_width)) ? w_acc : '0;
    end

endmodule : spike_pool_row_or
`default_nettype wire

// File: rtl/spike_maxpool2d_stream.sv
`default_nettype none
// ============================================================================
// Module  : spike_maxpool2d_stream
// Brief   : Runtime-configurable streaming 2-D max-pool for binary spike maps;
//           one input row per beat in, one pooled row per beat out.
// Revision: 1.0 - initial release
// ============================================================================
module spike_maxpool2d_stream
    import snn_pool_pkg::*;
#(
    parameter int IMG_WIDTH  = 32,
    parameter int TIME_STEPS = 4,
    parameter int CNT_W      = 16
) (
    input  wire                  s_clk,
    input  wire                  s_rst,
    input  wire                  cfg_valid,
    input  wire  [CNT_W-1:0]     cfg_img_size,
    input  wire  [CNT_W-1:0]     cfg_channels,
    input  wire  [1:0]           cfg_kernel,
    input  wire  [1:0]           cfg_stride,
    input  wire                  cfg_pad,
    output logic                 cfg_err,
    output logic                 o_done,
    output logic                 busy,
    spike_maxpool2d_stream_if.slave bus
);

    localparam int RW     = IMG_WIDTH * TIME_STEPS;
    localparam int Q_W    = CNT_W + 1;
    localparam int SPAN_W = CNT_W + 2;
    localparam logic [CNT_W-1:0] c_img_width = CNT_W'(IMG_WIDTH);

    pool_state_t      r_state;
    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_chans;
    logic [1:0]       r_k;
    logic [1:0]       r_s;
    logic             r_p;
    logic [CNT_W-1:0] r_ho;
    logic [CNT_W-1:0] r_v;
    logic [CNT_W-1:0] r_ch;
    logic [RW-1:0]    r_sr0;
    logic [RW-1:0]    r_sr1;
    logic             r_o_valid;
    logic [RW-1:0]    r_o_row;
    logic             r_done;
    logic             r_cfg_err;

    logic              w_cfg_ok;
    logic [SPAN_W-1:0] w_cfg_span;
    logic              w_slot_free;
    logic              w_i_ready;
    logic              w_accept;
    logic              w_flush_go;
    logic              w_shift;
    logic              w_last_row;
    logic              w_chan_end;
    logic [RW-1:0]     w_new_row;
    logic [RW-1:0]     w_vwin;
    logic [RW-1:0]     w_pooled;
    logic [Q_W-1:0]    w_q;
    logic [Q_W-1:0]    w_q_idx;
    logic              w_emit;

    assign w_cfg_span = SPAN_W'(cfg_img_size) + SPAN_W'({cfg_pad, 1'b0});
    assign w_cfg_ok   = (cfg_img_size != '0) && (cfg_img_size <= c_img_width)
                     && (cfg_channels != '0)
                     && (cfg_kernel >= c_kernel_min) && (cfg_kernel <= c_kernel_max)
                     && (cfg_stride >= c_stride_min) && (cfg_stride <= c_stride_max)
                     && (w_cfg_span >= SPAN_W'(cfg_kernel));

    assign w_slot_free = !r_o_valid || bus.o_ready;
    assign w_i_ready   = (r_state == ST_RUN) && w_slot_free;
    assign w_accept    = bus.i_valid && w_i_ready;
    assign w_flush_go  = (r_state == ST_FLUSH) && w_slot_free;
    assign w_shift     = w_accept || w_flush_go;
    assign w_last_row  = (r_v == r_h - CNT_W'(1));
    assign w_chan_end  = (w_accept && w_last_row && !r_p) || w_flush_go;

    // FLUSH shifts in the all-zero bottom-padding row.
    assign w_new_row = (r_state == ST_RUN) ? bus.i_row : '0;
    assign w_vwin    = w_new_row | r_sr0 | ((r_k == 2'd3) ? r_sr1 : '0);

    // q = v + p - k + 1, interpreted as signed; MSB set means q < 0.
    assign w_q     = Q_W'(r_v) + Q_W'(r_p) + Q_W'(1) - Q_W'(r_k);
    assign w_q_idx = (r_s == 2'd2) ? {1'b0, w_q[Q_W-1:1]} : w_q;
    assign w_emit  = !w_q[Q_W-1] && ((r_s == 2'd1) || !w_q[0]) && (w_q_idx < Q_W'(r_ho));

    spike_pool_row_or #(
        .IMG_WIDTH  (IMG_WIDTH),
        .TIME_STEPS (TIME_STEPS),
        .CNT_W      (CNT_W)
    ) u_row_or (
        .i_win_row    (w_vwin),
        .i_width      (r_h),
        .i_out_width  (r_ho),
        .i_kernel     (r_k),
        .i_stride     (r_s),
        .i_pad        (r_p),
        .o_pooled_row (w_pooled)
    );

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            r_state   <= ST_IDLE;
            r_h       <= '0;
            r_chans   <= '0;
            r_k       <= '0;
            r_s       <= '0;
            r_p       <= 1'b0;
            r_ho      <= '0;
            r_v       <= '0;
            r_ch      <= '0;
            r_sr0     <= '0;
            r_sr1     <= '0;
            r_o_valid <= 1'b0;
            r_o_row   <= '0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;

            if (r_o_valid && bus.o_ready)
                r_o_valid <= 1'b0;
            if (w_shift && w_emit) begin
                r_o_valid <= 1'b1;
                r_o_row   <= w_pooled;
            end
            if (w_shift) begin
                r_sr1 <= r_sr0;
                r_sr0 <= w_new_row;
                r_v   <= r_v + 1'b1;
            end

            unique case (r_state)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        if (w_cfg_ok) begin
                            r_h     <= cfg_img_size;
                            r_chans <= cfg_channels;
                            r_k     <= cfg_kernel;
                            r_s     <= cfg_stride;
                            r_p     <= cfg_pad;
                            r_ho    <= CNT_W'(calc_out_size(int'(cfg_img_size), int'(cfg_kernel),
                                                            int'(cfg_stride), int'(cfg_pad)));
                            r_v     <= '0;
                            r_ch    <= '0;
                            r_sr0   <= '0;
                            r_sr1   <= '0;
                            r_state <= ST_RUN;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_accept && w_last_row && r_p)
                        r_state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                end
                ST_DONE: begin
                    if (!r_o_valid || bus.o_ready) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Channel boundary: empty the window so the next channel sees top padding.
            if (w_chan_end) begin
                if (r_ch == r_chans - CNT_W'(1)) begin
                    r_state <= ST_DONE;
                end else begin
                    r_ch    <= r_ch + 1'b1;
                    r_v     <= '0;
                    r_sr0   <= '0;
                    r_sr1   <= '0;
                    r_state <= ST_RUN;
                end
            end
        end
    end

    assign bus.i_ready = w_i_ready;
    assign bus.o_valid = r_o_valid;
    assign bus.o_row   = r_o_row;
    assign cfg_err     = r_cfg_err;
    assign o_done      = r_done;
    assign busy        = (r_state != ST_IDLE);

endmodule : spike_maxpool2d_stream
`default_nettype wire

// File: tb/tb_spike_maxpool2d_stream.sv
`default_nettype none
// ============================================================================
// Module  : tb_spike_maxpool2d_stream
// Brief   : Self-checking bench: random spike maps against a direct 2-D window
//           reference, plus illegal-config and mid-frame reset scenarios.
// Revision: 1.0 - initial release
// ============================================================================
module tb_spike_maxpool2d_stream;

    localparam int IMG_WIDTH  = 32;
    localparam int TIME_STEPS = 4;
    localparam int CNT_W      = 16;
    localparam int RW         = IMG_WIDTH * TIME_STEPS;
    localparam int MAXC       = 4;

    logic             s_clk = 1'b0;
    logic             s_rst = 1'b1;
    logic             cfg_valid = 1'b0;
    logic [CNT_W-1:0] cfg_img_size = '0;
    logic [CNT_W-1:0] cfg_channels = '0;
    logic [1:0]       cfg_kernel = '0;
    logic [1:0]       cfg_stride = '0;
    logic             cfg_pad = 1'b0;
    logic             cfg_err;
    logic             o_done;
    logic             busy;

    spike_maxpool2d_stream_if #(.IMG_WIDTH(IMG_WIDTH), .TIME_STEPS(TIME_STEPS)) bus ();

    spike_maxpool2d_stream #(
        .IMG_WIDTH  (IMG_WIDTH),
        .TIME_STEPS (TIME_STEPS),
        .CNT_W      (CNT_W)
    ) dut (
        .s_clk        (s_clk),
        .s_rst        (s_rst),
        .cfg_valid    (cfg_valid),
        .cfg_img_size (cfg_img_size),
        .cfg_channels (cfg_channels),
        .cfg_kernel   (cfg_kernel),
        .cfg_stride   (cfg_stride),
        .cfg_pad      (cfg_pad),
        .cfg_err      (cfg_err),
        .o_done       (o_done),
        .busy         (busy),
        .bus          (bus)
    );

    always #5 s_clk = ~s_clk;

    logic [RW-1:0] img [MAXC][IMG_WIDTH];
    logic [RW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            out_cnt  = 0;
    int            done_cnt = 0;
    bit            rand_ready = 1'b0;
    bit            prev_stall = 1'b0;
    logic [RW-1:0] prev_row   = '0;

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [TIME_STEPS-1:0] pix(input int ch, input int r, input int c);
        logic [RW-1:0] row;
        row = img[ch][r];
        return row[c*TIME_STEPS +: TIME_STEPS];
    endfunction

    // Fill the input maps and queue the expected pooled rows, each computed
    // directly as the OR over its k x k window of the padded map.
    task automatic build_frame(input int h, input int c, input int k, input int s,
                               input int p, input int mode);
        int            ho;
        logic [RW-1:0] row;
        logic [TIME_STEPS-1:0] px;
        for (int ch = 0; ch < c; ch++) begin
            for (int r = 0; r < h; r++) begin
                row = '0;
                if (mode == 0) begin
                    for (int w = 0; w < RW / 32; w++)
                        row[w*32 +: 32] = $urandom & $urandom & $urandom;
                    for (int x = h; x < IMG_WIDTH; x++)
                        row[x*TIME_STEPS +: TIME_STEPS] = '0;
                end else if (mode == 1) begin
                    for (int x = 0; x < h; x++)
                        row[x*TIME_STEPS +: TIME_STEPS] = '1;
                end else begin
                    if (ch == 0 && r == 3)
                        row[3*TIME_STEPS] = 1'b1;
                end
                img[ch][r] = row;
            end
        end
        ho = (h + 2 * p - k) / s + 1;
        for (int ch = 0; ch < c; ch++) begin
            for (int i = 0; i < ho; i++) begin
                row = '0;
                for (int j = 0; j < ho; j++) begin
                    px = '0;
                    for (int dr = 0; dr < k; dr++) begin
                        for (int dc = 0; dc < k; dc++) begin
                            int rr, cc;
                            rr = i * s - p + dr;
                            cc = j * s - p + dc;
                            if (rr >= 0 && rr < h && cc >= 0 && cc < h)
                                px = px | pix(ch, rr, cc);
                        end
                    end
                    row[j*TIME_STEPS +: TIME_STEPS] = px;
                end
                exp_q.push_back(row);
            end
        end
    endtask

    task automatic illegal_cfg(input int h, input int c, input int k, input int s, input int p);
        @(posedge s_clk); #1;
        cfg_img_size = CNT_W'(h);
        cfg_channels = CNT_W'(c);
        cfg_kernel   = 2'(k);
        cfg_stride   = 2'(s);
        cfg_pad      = 1'(p);
        cfg_valid    = 1'b1;
        @(posedge s_clk); #1;
        cfg_valid = 1'b0;
        chk("illegal_cfg_err", cfg_err, 1);
        chk("illegal_busy", busy, 0);
        chk("illegal_i_ready", bus.i_ready, 0);
        @(posedge s_clk); #1;
        chk("illegal_err_pulse", cfg_err, 0);
        chk("illegal_still_idle", busy, 0);
    endtask

    task automatic drive_frame(input int h, input int c, input int k, input int s,
                               input int p, input int abort_after, input bit rnd);
        int n_exp;
        int beats;
        bit got;
        n_exp      = exp_q.size();
        out_cnt    = 0;
        done_cnt   = 0;
        rand_ready = rnd;
        @(posedge s_clk); #1;
        cfg_img_size = CNT_W'(h);
        cfg_channels = CNT_W'(c);
        cfg_kernel   = 2'(k);
        cfg_stride   = 2'(s);
        cfg_pad      = 1'(p);
        cfg_valid    = 1'b1;
        @(posedge s_clk); #1;
        cfg_img_size = '0;
        @(posedge s_clk); #1;
        chk("cfg_ignored_in_run", cfg_err, 0);
        chk("busy_in_run", busy, 1);
        cfg_valid = 1'b0;
        beats = 0;
        for (int ch = 0; ch < c; ch++) begin
            for (int r = 0; r < h; r++) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.i_valid = 1'b0;
                    @(posedge s_clk); #1;
                end
                bus.i_valid = 1'b1;
                bus.i_row   = img[ch][r];
                got = 1'b0;
                for (int t = 0; t < 200 && !got; t++) begin
                    @(negedge s_clk);
                    got = bus.i_ready;
                    @(posedge s_clk); #1;
                end
                if (!got) begin
                    chk("in_ready_timeout", 0, 1);
                    bus.i_valid = 1'b0;
                    return;
                end
                beats++;
                if (beats == abort_after) begin
                    bus.i_valid = 1'b0;
                    #2 s_rst = 1'b1;
                    #1;
                    chk("rst_o_valid", bus.o_valid, 0);
                    chk("rst_o_row", bus.o_row, 0);
                    chk("rst_busy", busy, 0);
                    chk("rst_i_ready", bus.i_ready, 0);
                    chk("rst_o_done", o_done, 0);
                    exp_q.delete();
                    prev_stall = 1'b0;
                    @(posedge s_clk); #1;
                    s_rst = 1'b0;
                    return;
                end
            end
        end
        bus.i_valid = 1'b0;
        for (int t = 0; t < 1000 && done_cnt == 0; t++)
            @(negedge s_clk);
        repeat (3) @(negedge s_clk);
        chk("done_pulses", done_cnt, 1);
        chk("out_rows", out_cnt, n_exp);
        chk("exp_drained", exp_q.size(), 0);
    endtask

    initial begin
        bus.i_valid = 1'b0;
        bus.i_row   = '0;
        bus.o_ready = 1'b1;

        fork
            forever begin
                @(posedge s_clk); #1;
                bus.o_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            forever begin
                @(negedge s_clk);
                if (s_rst) begin
                    prev_stall = 1'b0;
                end else begin
                    if (prev_stall) begin
                        chk("hold_valid", bus.o_valid, 1);
                        chk("hold_row", bus.o_row, prev_row);
                    end
                    if (o_done) begin
                        done_cnt++;
                        chk("done_no_valid", bus.o_valid, 0);
                    end
                    if (bus.o_valid && bus.o_ready) begin
                        out_cnt++;
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected_row actual=%h required=none", bus.o_row);
                        end else begin
                            chk("row", bus.o_row, exp_q.pop_front());
                        end
                    end
                    prev_stall = bus.o_valid && !bus.o_ready;
                    prev_row   = bus.o_row;
                end
            end
        join_none

        repeat (2) @(negedge s_clk);
        chk("reset_o_valid", bus.o_valid, 0);
        chk("reset_o_row", bus.o_row, 0);
        chk("reset_i_ready", bus.i_ready, 0);
        chk("reset_busy", busy, 0);
        chk("reset_cfg_err", cfg_err, 0);
        chk("reset_o_done", o_done, 0);
        @(posedge s_clk); #1;
        s_rst = 1'b0;

        illegal_cfg(0, 1, 3, 2, 1);
        illegal_cfg(40, 1, 3, 2, 1);
        illegal_cfg(8, 1, 1, 2, 1);
        illegal_cfg(1, 1, 3, 1, 0);
        illegal_cfg(8, 0, 3, 2, 1);
        illegal_cfg(8, 1, 3, 3, 1);

        // Single spike at (3,3), t=0: pooled rows 1 and 2 hold pixels 1,2 bit0.
        build_frame(8, 2, 3, 2, 1, 2);
        chk("pin_t1_count", exp_q.size(), 8);
        chk("pin_t1_r0", exp_q[0], 0);
        chk("pin_t1_r1", exp_q[1], 128'h110);
        chk("pin_t1_r2", exp_q[2], 128'h110);
        chk("pin_t1_r3", exp_q[3], 0);
        drive_frame(8, 2, 3, 2, 1, -1, 1'b0);

        build_frame(8, 2, 3, 1, 1, 1);
        chk("pin_t2_count", exp_q.size(), 16);
        chk("pin_t2_r0", exp_q[0], 128'hFFFF_FFFF);
        chk("pin_t2_r7", exp_q[7], 128'hFFFF_FFFF);
        drive_frame(8, 2, 3, 1, 1, -1, 1'b0);

        build_frame(6, 3, 2, 2, 0, 0);
        chk("pin_t3_count", exp_q.size(), 9);
        drive_frame(6, 3, 2, 2, 0, -1, 1'b0);

        build_frame(16, 4, 3, 2, 1, 0);
        chk("pin_t4_count", exp_q.size(), 32);
        drive_frame(16, 4, 3, 2, 1, -1, 1'b1);

        build_frame(8, 2, 3, 1, 1, 1);
        drive_frame(8, 2, 3, 1, 1, 5, 1'b1);
        build_frame(4, 2, 2, 2, 0, 0);
        chk("pin_t6_count", exp_q.size(), 4);
        drive_frame(4, 2, 2, 2, 0, -1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_spike_maxpool2d_stream
`default_nettype wire
